// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: FWFT FIFO with RTS hysteresis and overflow counting.
// Ports: clk, rst, flush_i, in_*, out_*, level_o, full_o, empty_o, ovf_o, drop_cnt_o, rts_n_o.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int HI_WM  = 12,
  parameter int LO_WM  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [DATA_W-1:0]          in_data_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [DATA_W-1:0]          out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic [7:0]                 drop_cnt_o,
  output logic                       rts_n_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] HI_L = LW'(HI_WM);
  localparam logic [LW-1:0] LO_L = LW'(LO_WM);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic          rts_q, rts_d;

  logic push;
  logic pop;
  logic drop;

  assign full_o      = (level_q == DEPTH_L);
  assign empty_o     = (level_q == '0);
  assign out_valid_o = !empty_o;
  assign pop         = out_valid_o && out_ready_i;
  assign in_ready_o  = !full_o || pop;
  assign push        = in_valid_i && in_ready_o && !flush_i;
  // A byte arriving during flush is thrown away silently, not counted.
  assign drop        = in_valid_i && !in_ready_o && !flush_i;

  assign out_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o     = level_q;
  assign ovf_o       = ovf_q;
  assign drop_cnt_o  = drop_q;
  assign rts_n_o     = rts_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    ovf_d    = 1'b0;
    rts_d    = rts_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      drop_d   = '0;
      rts_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + LW'(push) - LW'(pop);
      ovf_d   = drop;
      if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      // Between the watermarks the previous RTS state is held.
      if (level_d >= HI_L)      rts_d = 1'b1;
      else if (level_d <= LO_L) rts_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      rts_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      rts_q    <= rts_d;
    end
  end

  // Storage carries no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: table vectors, directed corners, random stream
// checked against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int HI_WM = 12;
  localparam int LO_WM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush_i = 1'b0;
  logic [7:0] in_data_i = '0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [4:0] level_o;
  logic       full_o;
  logic       empty_o;
  logic       ovf_o;
  logic [7:0] drop_cnt_o;
  logic       rts_n_o;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(8), .HI_WM(HI_WM), .LO_WM(LO_WM)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .level_o(level_o), .full_o(full_o), .empty_o(empty_o), .ovf_o(ovf_o),
    .drop_cnt_o(drop_cnt_o), .rts_n_o(rts_n_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model
  logic [7:0] mq[$];
  int         m_drop;
  bit         m_ovf;
  bit         m_rts;

  function automatic void model_reset();
    mq.delete();
    m_drop = 0;
    m_ovf = 0;
    m_rts = 0;
  endfunction

  function automatic bit model_ready(input bit ordy);
    return (mq.size() < DEPTH) || (ordy && mq.size() > 0);
  endfunction

  function automatic void model_step(input bit iv, input logic [7:0] d,
                                     input bit ordy, input bit fl);
    bit rdy;
    rdy = model_ready(ordy);
    if (fl) begin
      model_reset();
      return;
    end
    m_ovf = iv && !rdy;
    if (m_ovf && m_drop < 255) m_drop++;
    if (ordy && mq.size() > 0) void'(mq.pop_front());
    if (iv && rdy) mq.push_back(d);
    if (mq.size() >= HI_WM) m_rts = 1;
    else if (mq.size() <= LO_WM) m_rts = 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(level_o), 32'(mq.size()));
    chk("full", 32'(full_o), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty_o), 32'(mq.size() == 0));
    chk("out_valid", 32'(out_valid_o), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("out_data", 32'(out_data_o), 32'(mq[0]));
    chk("ovf", 32'(ovf_o), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    chk("rts_n", 32'(rts_n_o), 32'(m_rts));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(level_o), 32'd0);
    chk({tag, "_empty"}, 32'(empty_o), 32'd1);
    chk({tag, "_full"}, 32'(full_o), 32'd0);
    chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf_o), 32'd0);
    chk({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
    chk({tag, "_rts"}, 32'(rts_n_o), 32'd0);
  endtask

  // Called at posedge+1; samples combinational ready, then the next edge.
  task automatic drive(input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
    in_valid_i  = iv;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    #1;
    chk("in_ready", 32'(in_ready_o), 32'(model_ready(ordy)));
    @(posedge clk);
    model_step(iv, d, ordy, fl);
    #1;
    check_state();
  endtask

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         ordy;
    bit         fl;
    int         lvl;
    bit         vld;
    logic [7:0] dat;
    bit         ovf;
    int         drop;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int sent;
    int guard;
    bit iv;
    bit ordy;

    tbl[0] = '{1, 8'hA5, 0, 0, 1, 1, 8'hA5, 0, 0};
    tbl[1] = '{1, 8'h3C, 0, 0, 2, 1, 8'hA5, 0, 0};
    tbl[2] = '{0, 8'h00, 1, 0, 1, 1, 8'h3C, 0, 0};
    tbl[3] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0};

    #2 rst = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    check_reset_outputs("post_rst");

    // 1: two bytes through, table-driven
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("t1_level_%0d", i), 32'(level_o), 32'(tbl[i].lvl));
      chk($sformatf("t1_valid_%0d", i), 32'(out_valid_o), 32'(tbl[i].vld));
      if (tbl[i].vld) chk($sformatf("t1_data_%0d", i), 32'(out_data_o), 32'(tbl[i].dat));
      chk($sformatf("t1_ovf_%0d", i), 32'(ovf_o), 32'(tbl[i].ovf));
      chk($sformatf("t1_drop_%0d", i), 32'(drop_cnt_o), 32'(tbl[i].drop));
    end
    chk("t1_empty", 32'(empty_o), 32'd1);

    // 2: fill, then overflow
    for (int i = 0; i < 16; i++) drive(1, 8'(i), 0, 0);
    chk("t2_full", 32'(full_o), 32'd1);
    chk("t2_level", 32'(level_o), 32'd16);
    #1 chk("t2_in_ready", 32'(in_ready_o), 32'd0);
    drive(1, 8'hFF, 0, 0);
    chk("t2_ovf_pulse", 32'(ovf_o), 32'd1);
    chk("t2_drop1", 32'(drop_cnt_o), 32'd1);
    drive(0, 8'h00, 0, 0);
    chk("t2_ovf_clear", 32'(ovf_o), 32'd0);

    // 3: push and pop in the same cycle while full
    chk("t3_head", 32'(out_data_o), 32'h00);
    drive(1, 8'h77, 1, 0);
    chk("t3_level", 32'(level_o), 32'd16);
    chk("t3_no_ovf", 32'(ovf_o), 32'd0);
    chk("t3_drop", 32'(drop_cnt_o), 32'd1);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("t3_pop_%0d", i), 32'(out_data_o), 32'(i));
      drive(0, 8'h00, 1, 0);
    end
    chk("t3_last", 32'(out_data_o), 32'h77);
    drive(0, 8'h00, 1, 0);
    chk("t3_empty", 32'(empty_o), 32'd1);

    // 4: RTS hysteresis
    for (int i = 0; i < 12; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0);
      if (i == 10) chk("t4_rts_at_11", 32'(rts_n_o), 32'd0);
    end
    chk("t4_level12", 32'(level_o), 32'd12);
    chk("t4_rts_at_12", 32'(rts_n_o), 32'd1);
    for (int i = 0; i < 7; i++) drive(0, 8'h00, 1, 0);
    chk("t4_level5", 32'(level_o), 32'd5);
    chk("t4_rts_at_5", 32'(rts_n_o), 32'd1);
    drive(0, 8'h00, 1, 0);
    chk("t4_rts_at_4", 32'(rts_n_o), 32'd0);
    while (mq.size() > 0) drive(0, 8'h00, 1, 0);

    // 5: random stream across pointer wrap
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 2000) begin
      iv   = (mq.size() < 3) ? bit'($urandom_range(0, 1)) : 1'b0;
      ordy = bit'($urandom_range(0, 1));
      drive(iv, 8'($urandom), ordy, 0);
      if (iv) sent++;
      guard++;
    end
    chk("t5_sent", 32'(sent), 32'd40);
    guard = 0;
    while (mq.size() > 0 && guard < 100) begin
      drive(0, 8'h00, 1, 0);
      guard++;
    end
    chk("t5_drained", 32'(empty_o), 32'd1);
    for (int i = 0; i < 300; i++) drive(1, 8'(i), 0, 0);
    chk("t5_drop_sat", 32'(drop_cnt_o), 32'd255);
    chk("t5_ovf_held", 32'(ovf_o), 32'd1);

    // 6: flush with coincident push at level 9
    drive(0, 8'h00, 0, 1);
    for (int i = 0; i < 9; i++) drive(1, 8'(8'h90 + i), 0, 0);
    chk("t6_level9", 32'(level_o), 32'd9);
    drive(1, 8'h55, 0, 1);
    chk("t6_level", 32'(level_o), 32'd0);
    chk("t6_empty", 32'(empty_o), 32'd1);
    chk("t6_drop", 32'(drop_cnt_o), 32'd0);
    chk("t6_ovf", 32'(ovf_o), 32'd0);
    chk("t6_rts", 32'(rts_n_o), 32'd0);
    drive(1, 8'hC1, 0, 0);
    chk("t6_after_flush", 32'(out_data_o), 32'hC1);

    // 6b: async reset mid-burst with RTS high and a pending pop
    for (int i = 0; i < 13; i++) drive(1, 8'(8'hD0 + i), 0, 0);
    chk("t6_rts_pre", 32'(rts_n_o), 32'd1);
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    model_reset();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1 check_state();
    drive(1, 8'hE7, 0, 0);
    drive(0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
